// File: rtl/breakout_pkg.sv
// breakout_pkg
// Shared constants for the breakout game blocks: wall geometry, the
// game_state encoding, RGB565 colours, the brick-rectangle struct and a
// saturating score adder.
package breakout_pkg;

    localparam int ROWS        = 5;
    localparam int COLS        = 10;
    localparam int BRICK_W     = 64;
    localparam int BRICK_H     = 20;
    localparam int TOP         = 40;
    localparam int BALL_RADIUS = 5;
    localparam int GAP         = 2;

    // Width of a brick index (0..49)
    localparam int IDX_W       = 6;

    localparam logic [1:0] GS_START = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;
    localparam logic [1:0] GS_WIN   = 2'b10;
    localparam logic [1:0] GS_END   = 2'b11;

    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_ORANGE  = 16'hFC00;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_GRAY    = 16'h8410;

    // Inclusive pixel bounds of one brick cell
    typedef struct packed {
        logic [9:0] x0;
        logic [9:0] y0;
        logic [9:0] x1;
        logic [9:0] y1;
    } rect_t;

    // Score adder that sticks at 1023 instead of wrapping
    function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [1:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + {9'b0, b};
        return sum[10] ? 10'h3FF : sum[9:0];
    endfunction

endpackage

// File: rtl/brick_rect.sv
// brick_rect
// Combinational brick index -> cell rectangle for the wall scanner.
// Ports:
//   idx   in   IDX_W  brick index, row*COLS+col
//   rect  out  rect_t inclusive bounds (x0, y0, x1, y1)
module brick_rect
    import breakout_pkg::*;
#(
    parameter int ROWS    = breakout_pkg::ROWS,
    parameter int COLS    = breakout_pkg::COLS,
    parameter int BRICK_W = breakout_pkg::BRICK_W,
    parameter int BRICK_H = breakout_pkg::BRICK_H,
    parameter int TOP     = breakout_pkg::TOP
) (
    input  logic [IDX_W-1:0] idx,
    output rect_t            rect
);

    int row_i;
    int col_i;

    // Row comes from a comparator chain against multiples of COLS; the
    // column is then the remainder, so no divider is needed.
    always_comb begin
        row_i = 0;
        for (int r = 1; r < ROWS; r++) begin
            if (int'(idx) >= r * COLS) row_i = r;
        end
        col_i   = int'(idx) - row_i * COLS;
        rect.x0 = 10'(col_i * BRICK_W);
        rect.x1 = 10'(col_i * BRICK_W + BRICK_W - 1);
        rect.y0 = 10'(TOP + row_i * BRICK_H);
        rect.y1 = 10'(TOP + row_i * BRICK_H + BRICK_H - 1);
    end

endmodule

// File: rtl/brick_field.sv
// brick_field
// Owns the brick wall: per-brick alive/cracked state, a one-brick-per-cycle
// overlap scan triggered by ball movement, score / bricks-left / win
// bookkeeping and the brick pixel colour for the pixel mux.
// Ports:
//   vga_clk          in   1        pixel clock
//   sys_rst_n        in   1        async active-low reset
//   game_reset       in   1        synchronous wall restore
//   game_state       in   2        START / PLAY / WIN / END
//   ball_x, ball_y   in   10 each  ball centre
//   pix_x, pix_y     in   10 each  current pixel
//   brick_collision  out  50       one-cycle one-hot hit pulse
//   score            out  10       saturating points
//   bricks_left      out  6        bricks not yet destroyed
//   win_sig          out  1        sticky, high once bricks_left hits 0
//   pix_data         out  16       RGB565 brick colour, 0 when no brick
//
// state   | meaning
// IDLE    | waiting for a ball move (or a move queued during a scan)
// SCAN    | testing brick idx against the ball, one brick per cycle
// REPORT  | pulse brick_collision[idx] and apply the hit
module brick_field
    import breakout_pkg::*;
#(
    parameter int ROWS        = breakout_pkg::ROWS,
    parameter int COLS        = breakout_pkg::COLS,
    parameter int BRICK_W     = breakout_pkg::BRICK_W,
    parameter int BRICK_H     = breakout_pkg::BRICK_H,
    parameter int TOP         = breakout_pkg::TOP,
    parameter int BALL_RADIUS = breakout_pkg::BALL_RADIUS,
    parameter int GAP         = breakout_pkg::GAP
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst_n,
    input  logic                 game_reset,
    input  logic [1:0]           game_state,
    input  logic [9:0]           ball_x,
    input  logic [9:0]           ball_y,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    output logic [ROWS*COLS-1:0] brick_collision,
    output logic [9:0]           score,
    output logic [5:0]           bricks_left,
    output logic                 win_sig,
    output logic [15:0]          pix_data
);

    localparam int NB = ROWS * COLS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic [NB-1:0]    alive;
    logic [NB-1:0]    cracked;
    logic [9:0]       prev_x;
    logic [9:0]       prev_y;

    logic  playing;
    logic  move;
    logic  hit;
    logic  scan_row0;
    rect_t rect;

    assign playing   = (game_state == GS_PLAY);
    assign move      = playing && ((ball_x != prev_x) || (ball_y != prev_y));
    assign scan_row0 = (int'(idx) < COLS);

    // prev_x/prev_y follow the ball every cycle with the clock running through
    // reset, so they already equal the ball when any reset releases and no
    // spurious move is seen.
    always_ff @(posedge vga_clk) begin
        prev_x <= ball_x;
        prev_y <= ball_y;
    end

    brick_rect #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .BRICK_W (BRICK_W),
        .BRICK_H (BRICK_H),
        .TOP     (TOP)
    ) u_brick_rect (
        .idx  (idx),
        .rect (rect)
    );

    // Radius is added to the ball side or the brick side so nothing is
    // subtracted; 11 bits keep x1+R from wrapping at the right edge.
    logic [10:0] bx_ext;
    logic [10:0] by_ext;
    assign bx_ext = {1'b0, ball_x};
    assign by_ext = {1'b0, ball_y};

    assign hit = (bx_ext + 11'(BALL_RADIUS) >= {1'b0, rect.x0})
              && (bx_ext <= {1'b0, rect.x1} + 11'(BALL_RADIUS))
              && (by_ext + 11'(BALL_RADIUS) >= {1'b0, rect.y0})
              && (by_ext <= {1'b0, rect.y1} + 11'(BALL_RADIUS))
              && alive[idx];

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            alive       <= '1;
            cracked     <= '0;
            score       <= '0;
            bricks_left <= 6'(NB);
            win_sig     <= 1'b0;
        end else if (game_reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            alive       <= '1;
            cracked     <= '0;
            score       <= '0;
            bricks_left <= 6'(NB);
            win_sig     <= 1'b0;
        end else begin
            if (bricks_left == '0) win_sig <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (move || pending) begin
                        state   <= ST_SCAN;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!playing) begin
                        state   <= ST_IDLE;
                        pending <= 1'b0;
                    end else begin
                        if (move) pending <= 1'b1;
                        if (hit) begin
                            state <= ST_REPORT;
                        end else if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    state <= ST_IDLE;
                    if (!playing) begin
                        pending <= 1'b0;
                    end else if (scan_row0 && !cracked[idx]) begin
                        cracked[idx] <= 1'b1;
                    end else begin
                        alive[idx]  <= 1'b0;
                        score       <= sat_add10(score, scan_row0 ? 2'd3 : 2'd1);
                        bricks_left <= bricks_left - 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pulse is decoded from REPORT and gated by the same conditions that
    // block the update, so an aborted or reset report never reaches physics.
    always_comb begin
        brick_collision = '0;
        if ((state == ST_REPORT) && playing && !game_reset) brick_collision[idx] = 1'b1;
    end

    // Pixel path: own row decode by comparator chain, column from pix_x[9:6]
    logic [2:0]       pix_row;
    logic             in_wall;
    logic [9:0]       row_top;
    logic [9:0]       local_y;
    logic [3:0]       pix_col;
    logic [IDX_W-1:0] pix_idx;
    logic             brick_lit;
    logic [15:0]      row_colour;

    always_comb begin
        pix_row = '0;
        in_wall = 1'b0;
        row_top = 10'(TOP);
        for (int r = 0; r < ROWS; r++) begin
            if ((int'(pix_y) >= TOP + r * BRICK_H) && (int'(pix_y) < TOP + (r + 1) * BRICK_H)) begin
                in_wall = 1'b1;
                pix_row = 3'(r);
                row_top = 10'(TOP + r * BRICK_H);
            end
        end
        pix_col = pix_x[9:6];
        pix_idx = IDX_W'(int'(pix_row) * COLS + int'(pix_col));
        local_y = pix_y - row_top;

        brick_lit = playing && in_wall
                 && (int'(pix_col) < COLS)
                 && (int'(pix_x[5:0]) < BRICK_W - GAP)
                 && (int'(local_y) < BRICK_H - GAP)
                 && alive[pix_idx];

        case (pix_row)
            3'd0:    row_colour = cracked[pix_idx] ? RGB_GRAY : RGB_RED;
            3'd1:    row_colour = RGB_ORANGE;
            3'd2:    row_colour = RGB_YELLOW;
            3'd3:    row_colour = RGB_CYAN;
            default: row_colour = RGB_MAGENTA;
        endcase

        pix_data = brick_lit ? row_colour : RGB_BLACK;
    end

endmodule
